// File: rtl/pkt_sche_v0_3.sv
// Priority packet scheduler: per-class FIFOs plus an urgent FIFO feeding a show-ahead output register.
// Define PKT_SCHE_AGING_EN to compile in anti-starvation aging of class queues.
module pkt_sche_v0_3 #(
  parameter int DWIDTH      = 32,
  parameter int PRIOR_WIDTH = 6,
  parameter int NUM_CLASS   = 4,
  parameter int QUEUE_SIZE  = 16,
  parameter int AGE_LIMIT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  output logic                   in_valid,
  input  logic                   in_ugr,
  input  logic [PRIOR_WIDTH-1:0] in_prior,
  input  logic [DWIDTH-1:0]      in_data,
  input  logic                   out_deque_en,
  output logic                   out_valid,
  output logic [DWIDTH-1:0]      out_data,
  output logic [PRIOR_WIDTH-1:0] out_prior,
  output logic                   out_ugr,
  output logic [NUM_CLASS:0]     q_empty,
  output logic [15:0]            drop_cnt
);

  localparam int NQ    = NUM_CLASS + 1;  // index NUM_CLASS is the urgent queue
  localparam int CLS_W = $clog2(NUM_CLASS);
  localparam int QW    = $clog2(NQ);
  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = PRIOR_WIDTH + DWIDTH;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_SIZE);
  localparam logic [QW-1:0]    UGR_IDX  = QW'(NUM_CLASS);

  logic [EW-1:0]    mem_q    [NQ][QUEUE_SIZE];
  logic [PTR_W-1:0] wr_ptr_q [NQ];
  logic [PTR_W-1:0] wr_ptr_d [NQ];
  logic [PTR_W-1:0] rd_ptr_q [NQ];
  logic [PTR_W-1:0] rd_ptr_d [NQ];
  logic [CNT_W-1:0] cnt_q    [NQ];
  logic [CNT_W-1:0] cnt_d    [NQ];

  logic [NQ-1:0]    ne_vec, full_vec, push_vec, pop_vec;
  logic             push, load, sel_ok;
  logic [QW-1:0]    push_idx, sel;
  logic [EW-1:0]    push_entry;

  logic                   out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]      out_data_q, out_data_d;
  logic [PRIOR_WIDTH-1:0] out_prior_q, out_prior_d;
  logic                   out_ugr_q, out_ugr_d;
  logic [15:0]            drop_q, drop_d;

  always_comb begin
    ne_vec   = '0;
    full_vec = '0;
    for (int i = 0; i < NQ; i++) begin
      ne_vec[i]   = (cnt_q[i] != '0);
      full_vec[i] = (cnt_q[i] == FULL_CNT);
    end
  end

  assign in_valid   = ~|full_vec;
  assign push       = in_en && in_valid;
  assign push_idx   = in_ugr ? UGR_IDX : QW'(in_prior[PRIOR_WIDTH-1 -: CLS_W]);
  assign push_entry = in_ugr ? {{PRIOR_WIDTH{1'b0}}, in_data} : {in_prior, in_data};
  assign push_vec   = push ? (NQ'(1) << push_idx) : '0;

`ifdef PKT_SCHE_AGING_EN
  localparam logic [4:0] AGE_LIM = 5'(AGE_LIMIT);

  logic [3:0]           age_q [NUM_CLASS];
  logic [3:0]           age_d [NUM_CLASS];
  logic [NUM_CLASS-1:0] aged_vec;

  always_comb begin
    aged_vec = '0;
    for (int c = 0; c < NUM_CLASS; c++) begin
      aged_vec[c] = ne_vec[c] && ({1'b0, age_q[c]} >= AGE_LIM);
      age_d[c]    = age_q[c];
      if (!ne_vec[c]) begin
        age_d[c] = '0;
      end else if (load && sel_ok) begin
        if (sel == QW'(c))          age_d[c] = '0;
        else if (age_q[c] != 4'hF) age_d[c] = age_q[c] + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NUM_CLASS; c++) age_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CLASS; c++) age_q[c] <= age_d[c];
    end
  end
`else
  logic unused_age_limit;
  assign unused_age_limit = ^AGE_LIMIT;
`endif

  // Selection looks only at registered counts, so an entry pushed this edge waits one cycle.
  always_comb begin
    sel    = '0;
    sel_ok = |ne_vec;
    for (int c = 0; c < NUM_CLASS; c++) begin
      if (ne_vec[c]) sel = QW'(c);
    end
`ifdef PKT_SCHE_AGING_EN
    for (int c = NUM_CLASS - 1; c >= 0; c--) begin
      if (aged_vec[c]) sel = QW'(c);
    end
`endif
    if (ne_vec[NUM_CLASS]) sel = UGR_IDX;
  end

  assign load    = !out_valid_q || out_deque_en;
  assign pop_vec = (load && sel_ok) ? (NQ'(1) << sel) : '0;

  // NOTE: every variable gets its default first so no path through the block infers a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_prior_d = out_prior_q;
    out_ugr_d   = out_ugr_q;
    if (load) begin
      out_valid_d = sel_ok;
      out_ugr_d   = sel_ok && (sel == UGR_IDX);
      if (sel_ok) {out_prior_d, out_data_d} = mem_q[sel][rd_ptr_q[sel]];
      else        {out_prior_d, out_data_d} = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < NQ; i++) begin
      wr_ptr_d[i] = push_vec[i] ? wr_ptr_q[i] + PTR_W'(1) : wr_ptr_q[i];
      rd_ptr_d[i] = pop_vec[i]  ? rd_ptr_q[i] + PTR_W'(1) : rd_ptr_q[i];
      case ({push_vec[i], pop_vec[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  assign drop_d = (in_en && !in_valid && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;

  // NOTE: storage carries no reset; the cleared counts already mark every slot as invalid.
  always_ff @(posedge clk) begin
    if (push) mem_q[push_idx][wr_ptr_q[push_idx]] <= push_entry;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_prior_q <= '0;
      out_ugr_q   <= 1'b0;
      drop_q      <= '0;
    end else begin
      for (int i = 0; i < NQ; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_prior_q <= out_prior_d;
      out_ugr_q   <= out_ugr_d;
      drop_q      <= drop_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_prior = out_prior_q;
  assign out_ugr   = out_ugr_q;
  assign q_empty   = ~ne_vec;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pkt_sche_v0_3.sv
// Scoreboard bench for pkt_sche_v0_3: directed pushes queue their expected outputs,
// a negedge monitor compares every popped head entry.
module tb_pkt_sche_v0_3;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_en, in_valid, in_ugr;
  logic [5:0]  in_prior;
  logic [31:0] in_data;
  logic        out_deque_en, out_valid, out_ugr;
  logic [31:0] out_data;
  logic [5:0]  out_prior;
  logic [4:0]  q_empty;
  logic [15:0] drop_cnt;

  typedef struct {
    logic [31:0] data;
    logic [5:0]  prior;
    logic        ugr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  pkt_sche_v0_3 dut (
    .clk          (clk),
    .rst          (rst),
    .in_en        (in_en),
    .in_valid     (in_valid),
    .in_ugr       (in_ugr),
    .in_prior     (in_prior),
    .in_data      (in_data),
    .out_deque_en (out_deque_en),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_prior    (out_prior),
    .out_ugr      (out_ugr),
    .q_empty      (q_empty),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_add(input logic [31:0] data, input logic [5:0] prior, input logic ugr);
    exp_t e;
    e.data  = data;
    e.prior = prior;
    e.ugr   = ugr;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic ugr, input logic [5:0] prior, input logic [31:0] data);
    in_en    = 1'b1;
    in_ugr   = ugr;
    in_prior = prior;
    in_data  = data;
    cyc();
    in_en    = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc();
    cyc();
    check(name, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  // Monitor: the head is consumed at the next rising edge whenever valid and deque are both high.
  always @(negedge clk) begin
    if (rst && out_valid && out_deque_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got data=%0h prior=%0h ugr=%0b, expected no output",
                 out_data, out_prior, out_ugr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data",  64'(out_data),  64'(e.data));
        check("out_prior", 64'(out_prior), 64'(e.prior));
        check("out_ugr",   64'(out_ugr),   64'(e.ugr));
      end
    end
  end

  initial begin
    rst          = 1'b0;
    in_en        = 1'b0;
    in_ugr       = 1'b0;
    in_prior     = '0;
    in_data      = '0;
    out_deque_en = 1'b0;

    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_prior", 64'(out_prior), 64'd0);
    check("rst_out_ugr",   64'(out_ugr),   64'd0);
    check("rst_q_empty",   64'(q_empty),   64'h1F);
    check("rst_drop_cnt",  64'(drop_cnt),  64'd0);
    #5 rst = 1'b1;
    cyc();
    check("post_rst_in_valid", 64'(in_valid), 64'd1);

    // Single entry into idle block: visible one edge after acceptance.
    out_deque_en = 1'b1;
    exp_add(32'hA, 6'h3F, 1'b0);
    push(1'b0, 6'h3F, 32'hA);
    check("lat_accept_edge", 64'(out_valid), 64'd0);
    cyc();
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_data",  64'(out_data),  64'hA);
    cyc();
    check("lat_popped", 64'(out_valid), 64'd0);

    // Filler parks in the output register; the three queued entries then leave by class.
    out_deque_en = 1'b0;
    push(1'b0, 6'h10, 32'h0F);
    push(1'b0, 6'h05, 32'h105);
    push(1'b0, 6'h2A, 32'h12A);
    push(1'b0, 6'h3C, 32'h13C);
    exp_add(32'h0F,  6'h10, 1'b0);
    exp_add(32'h13C, 6'h3C, 1'b0);
    exp_add(32'h12A, 6'h2A, 1'b0);
    exp_add(32'h105, 6'h05, 1'b0);
    out_deque_en = 1'b1;
    drain("drain_order", 20);

    // Urgent entry overtakes queued class-3 entries but not the current head.
    out_deque_en = 1'b0;
    push(1'b0, 6'h30, 32'hC1);
    push(1'b0, 6'h31, 32'hC2);
    push(1'b0, 6'h32, 32'hC3);
    push(1'b1, 6'h3F, 32'hBEEF);
    cyc();
    check("ugr_head", 64'(out_data), 64'hC1);
    exp_add(32'hC1,   6'h30, 1'b0);
    exp_add(32'hBEEF, 6'h00, 1'b1);
    exp_add(32'hC2,   6'h31, 1'b0);
    exp_add(32'hC3,   6'h32, 1'b0);
    out_deque_en = 1'b1;
    drain("drain_urgent", 20);

    // Fill class 0 behind a parked urgent head, then overflow once.
    out_deque_en = 1'b0;
    push(1'b1, 6'h00, 32'hF00D);
    for (int i = 0; i < 16; i++) begin
      push(1'b0, 6'h00, 32'h100 + 32'(i));
      if (i == 14) check("full_minus_one_in_valid", 64'(in_valid), 64'd1);
    end
    check("full_in_valid",   64'(in_valid),   64'd0);
    check("full_q_empty0",   64'(q_empty[0]), 64'd0);
    push(1'b0, 6'h00, 32'hDEAD);
    check("full_drop_cnt",   64'(drop_cnt),   64'd1);
    check("full_q_empty0_b", 64'(q_empty[0]), 64'd0);
    exp_add(32'hF00D, 6'h00, 1'b1);
    for (int i = 0; i < 16; i++) exp_add(32'h100 + 32'(i), 6'h00, 1'b0);
    out_deque_en = 1'b1;
    cyc();
    check("full_release_in_valid", 64'(in_valid), 64'd1);
    drain("drain_full", 40);

    // Mid-stream reset discards everything queued or held.
    out_deque_en = 1'b0;
    push(1'b0, 6'h3F, 32'h1);
    push(1'b0, 6'h20, 32'h2);
    push(1'b0, 6'h10, 32'h3);
    push(1'b0, 6'h00, 32'h4);
    push(1'b1, 6'h00, 32'h5);
    push(1'b0, 6'h3F, 32'h6);
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_q_empty",   64'(q_empty),   64'h1F);
    cyc();
    rst = 1'b1;
    out_deque_en = 1'b1;
    repeat (10) cyc();
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    check("after_rst_q_empty",   64'(q_empty),   64'h1F);
    check("after_rst_drop_cnt",  64'(drop_cnt),  64'd0);
    check("after_rst_in_valid",  64'(in_valid),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
